// File: rtl/memory_bus_pkg.sv
// Shared memory-handshake types: command encoding and responder FSM states.
// Used by the responder, the multi-cycle controller and the bench.
package memory_bus_pkg;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  typedef enum logic [1:0] {IDLE, WAIT, RESPOND} responder_state_t;

endpackage

// File: rtl/byte_enable_ram.sv
// Single-port word RAM with per-byte write enables and a registered, read-enabled output.
// One-cycle read latency; no backpressure, every enabled access completes on its edge.
module byte_enable_ram #(
  parameter int    DEPTH     = 4096,
  parameter string INIT_FILE = "",
  localparam int   AW        = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          write_enable,
  input  logic [3:0]    byte_enable,
  input  logic          read_enable,
  input  logic [AW-1:0] address,
  input  logic [31:0]   write_data,
  output logic [31:0]   read_data
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (write_enable) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_enable[b]) mem[address][8*b +: 8] <= write_data[8*b +: 8];
      end
    end
    if (read_enable) read_data <= mem[address];
  end

endmodule

// File: rtl/memory_responder.sv
// Memory target: one request at a time, answered LATENCY cycles after accept with a one-cycle valid.
// Backpressure: memory_ready is low from the cycle after accept through the valid cycle; enables then are ignored.
module memory_responder
  import memory_bus_pkg::*;
#(
  parameter int    ADDR_WIDTH = 12,
  parameter int    LATENCY    = 2,
  parameter string INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memory_enable,
  input  logic        memory_command,
  input  logic [31:0] memory_address,
  input  logic [31:0] memory_write_data,
  input  logic [3:0]  memory_write_mask,
  output logic        memory_ready,
  output logic        memory_valid,
  output logic [31:0] memory_read_data,
  output logic        memory_fault
);

  localparam logic [3:0] COUNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  responder_state_t        state;
  logic [3:0]              count;
  logic                    req_command;
  logic                    req_fault;
  logic [ADDR_WIDTH-1:0]   req_word;
  logic [31:0]             req_write_data;
  logic [3:0]              req_write_mask;
  logic                    read_data_ok;
  logic [31:0]             ram_read_data;

  logic                    accept;
  logic                    address_fault;
  logic                    enter_respond;
  logic                    bypass;
  logic                    cur_command;
  logic                    cur_fault;
  logic [ADDR_WIDTH-1:0]   cur_word;
  logic [31:0]             cur_write_data;
  logic [3:0]              cur_write_mask;
  logic                    ram_write;
  logic                    ram_read;

  assign accept        = (state == IDLE) && memory_enable;
  assign address_fault = (memory_address[1:0] != 2'b00) ||
                         ((memory_address >> (ADDR_WIDTH + 2)) != 32'd0);

  // With LATENCY=1 the RAM access happens on the accept edge itself, so the
  // request comes straight from the bus rather than from the latch.
  assign bypass         = (state == IDLE);
  assign cur_command    = bypass ? memory_command    : req_command;
  assign cur_fault      = bypass ? address_fault     : req_fault;
  assign cur_word       = bypass ? memory_address[ADDR_WIDTH+1:2] : req_word;
  assign cur_write_data = bypass ? memory_write_data : req_write_data;
  assign cur_write_mask = bypass ? memory_write_mask : req_write_mask;

  assign enter_respond = (LATENCY == 1) ? accept : ((state == WAIT) && (count == 4'd0));
  assign ram_write     = enter_respond && !reset && (cur_command == MEM_WRITE) && !cur_fault;
  assign ram_read      = enter_respond && (cur_command == MEM_READ) && !cur_fault;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      count        <= 4'd0;
      read_data_ok <= 1'b0;
    end else begin
      if (enter_respond && (cur_command == MEM_READ)) read_data_ok <= !cur_fault;
      case (state)
        IDLE: begin
          if (memory_enable) begin
            req_command    <= memory_command;
            req_fault      <= address_fault;
            req_word       <= memory_address[ADDR_WIDTH+1:2];
            req_write_data <= memory_write_data;
            req_write_mask <= memory_write_mask;
            count          <= COUNT_INIT;
            state          <= (LATENCY == 1) ? RESPOND : WAIT;
          end
        end
        WAIT: begin
          if (count == 4'd0) state <= RESPOND;
          else               count <= count - 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  byte_enable_ram #(
    .DEPTH     (2 ** ADDR_WIDTH),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk          (clk),
    .write_enable (ram_write),
    .byte_enable  (cur_write_mask),
    .read_enable  (ram_read),
    .address      (cur_word),
    .write_data   (cur_write_data),
    .read_data    (ram_read_data)
  );

  assign memory_ready     = (state == IDLE);
  assign memory_valid     = (state == RESPOND);
  assign memory_fault     = (state == RESPOND) && req_fault;
  assign memory_read_data = read_data_ok ? ram_read_data : 32'd0;

endmodule

// File: tb/tb_memory_responder.sv
// Bench for memory_responder: four instances (LATENCY 1,2,3,5), vector table, hand sequences
// for hold-enable and reset corners, and randomized traffic against a word-array model.
module tb_memory_responder;

  localparam int NI = 4;
  localparam int LATS [NI] = '{1, 2, 3, 5};

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NI-1:0]     en = '0;
  logic              cmd = 1'b0;
  logic [31:0]       addr = '0;
  logic [31:0]       wdata = '0;
  logic [3:0]        mask = '0;
  logic [NI-1:0]     ready, valid, fault;
  logic [31:0]       rdata [NI];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    memory_responder #(
      .ADDR_WIDTH (12),
      .LATENCY    (LATS[g]),
      .INIT_FILE  ("")
    ) dut (
      .clk               (clk),
      .reset             (reset),
      .memory_enable     (en[g]),
      .memory_command    (cmd),
      .memory_address    (addr),
      .memory_write_data (wdata),
      .memory_write_mask (mask),
      .memory_ready      (ready[g]),
      .memory_valid      (valid[g]),
      .memory_read_data  (rdata[g]),
      .memory_fault      (fault[g])
    );
  end

  typedef struct {
    bit          cmd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [31:0] exp_rd;
    bit          exp_flt;
  } vec_t;

  // Reference state: 16-word window at 0x200 per instance, plus last read data per instance.
  logic [31:0] mdl [NI][16];
  logic [31:0] last_rd [NI];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One transaction on instance i; checks the exact valid cycle and ready shape.
  task automatic do_op(input int i, input bit c, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] m, input bit hold,
                       output logic [31:0] rd, output logic flt);
    int lat;
    lat = LATS[i];
    @(negedge clk);
    chk($sformatf("ready_before_accept[%0d]", i), 32'(ready[i]), 32'd1);
    en[i] = 1'b1; cmd = c; addr = a; wdata = d; mask = m;
    @(negedge clk);
    if (hold) begin
      addr = a + 32'd4; wdata = 32'h9999_9999;
    end else begin
      en[i] = 1'b0;
    end
    for (int k = 1; k <= lat; k++) begin
      chk($sformatf("valid_cycle%0d[%0d]", k, i), 32'(valid[i]), 32'(k == lat));
      chk($sformatf("ready_busy%0d[%0d]", k, i), 32'(ready[i]), 32'd0);
      if (k < lat) chk($sformatf("fault_quiet%0d[%0d]", k, i), 32'(fault[i]), 32'd0);
      if (k < lat) @(negedge clk);
    end
    rd = rdata[i];
    flt = fault[i];
    en[i] = 1'b0;
    @(negedge clk);
    chk($sformatf("ready_after[%0d]", i), 32'(ready[i]), 32'd1);
    chk($sformatf("valid_after[%0d]", i), 32'(valid[i]), 32'd0);
    chk($sformatf("fault_after[%0d]", i), 32'(fault[i]), 32'd0);
  endtask

  initial begin
    vec_t        vecs [12];
    logic [31:0] rd;
    logic        flt;

    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         4'b0000, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0010, 32'h0000_AA00, 4'b0010, 32'hDEAD_BEEF, 1'b0};
    vecs[3]  = '{1'b0, 32'h0000_0010, 32'h0,         4'b0000, 32'hDEAD_AAEF, 1'b0};
    vecs[4]  = '{1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'b0000, 32'hDEAD_AAEF, 1'b0};
    vecs[5]  = '{1'b0, 32'h0000_0010, 32'h0,         4'b0000, 32'hDEAD_AAEF, 1'b0};
    vecs[6]  = '{1'b0, 32'h0000_0012, 32'h0,         4'b0000, 32'h0000_0000, 1'b1};
    vecs[7]  = '{1'b0, 32'h0000_4000, 32'h0,         4'b0000, 32'h0000_0000, 1'b1};
    vecs[8]  = '{1'b1, 32'h0000_0012, 32'h5555_5555, 4'b1111, 32'h0000_0000, 1'b1};
    vecs[9]  = '{1'b0, 32'h0000_0010, 32'h0,         4'b0000, 32'hDEAD_AAEF, 1'b0};
    vecs[10] = '{1'b1, 32'h0000_3FFC, 32'h0102_0304, 4'b1111, 32'hDEAD_AAEF, 1'b0};
    vecs[11] = '{1'b0, 32'h0000_3FFC, 32'h0,         4'b0000, 32'h0102_0304, 1'b0};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("reset_ready[%0d]", i), 32'(ready[i]), 32'd1);
      chk($sformatf("reset_valid[%0d]", i), 32'(valid[i]), 32'd0);
      chk($sformatf("reset_fault[%0d]", i), 32'(fault[i]), 32'd0);
      chk($sformatf("reset_rdata[%0d]", i), rdata[i], 32'd0);
      last_rd[i] = 32'd0;
    end

    // Vector table on the LATENCY=2 instance.
    foreach (vecs[v]) begin
      do_op(1, vecs[v].cmd, vecs[v].addr, vecs[v].wdata, vecs[v].mask, 1'b0, rd, flt);
      chk($sformatf("vec%0d_rdata", v), rd, vecs[v].exp_rd);
      chk($sformatf("vec%0d_fault", v), 32'(flt), 32'(vecs[v].exp_flt));
    end
    last_rd[1] = 32'h0102_0304;

    // Enable held high with a new address through WAIT on LATENCY=5: only the first request lands.
    do_op(3, 1'b1, 32'h40, 32'h1111_1111, 4'hF, 1'b0, rd, flt);
    do_op(3, 1'b1, 32'h44, 32'h2222_2222, 4'hF, 1'b0, rd, flt);
    do_op(3, 1'b1, 32'h40, 32'hAAAA_5555, 4'hF, 1'b1, rd, flt);
    repeat (3) begin
      @(negedge clk);
      chk("hold_no_second_valid", 32'(valid[3]), 32'd0);
    end
    do_op(3, 1'b0, 32'h44, 32'h0, 4'h0, 1'b0, rd, flt);
    chk("hold_ignored_addr", rd, 32'h2222_2222);
    do_op(3, 1'b0, 32'h40, 32'h0, 4'h0, 1'b0, rd, flt);
    chk("hold_first_addr", rd, 32'hAAAA_5555);
    last_rd[3] = rd;

    // Randomized traffic on every instance against the word model.
    for (int i = 0; i < NI; i++) begin
      for (int w = 0; w < 16; w++) begin
        mdl[i][w] = $urandom;
        do_op(i, 1'b1, 32'h200 + 32'(4 * w), mdl[i][w], 4'hF, 1'b0, rd, flt);
      end
      for (int n = 0; n < 50; n++) begin
        bit          c;
        int          w;
        logic [31:0] a, d, exp_rd;
        logic [3:0]  m;
        bit          exp_f;
        c = 1'($urandom_range(0, 1));
        w = $urandom_range(0, 15);
        d = $urandom;
        m = 4'($urandom_range(0, 15));
        a = 32'h200 + 32'(4 * w);
        case ($urandom_range(0, 9))
          0: a = a + 32'($urandom_range(1, 3));
          1: a = 32'h4000 + 32'(4 * $urandom_range(0, 1000));
          2: a = 32'h8000_0000 | a;
          default: ;
        endcase
        exp_f = (a % 4 != 0) || (a >= 32'h4000);
        if (c) begin
          exp_rd = last_rd[i];
          if (!exp_f)
            for (int b = 0; b < 4; b++)
              if (m[b]) mdl[i][w][8*b +: 8] = d[8*b +: 8];
        end else begin
          exp_rd = exp_f ? 32'd0 : mdl[i][w];
          last_rd[i] = exp_rd;
        end
        do_op(i, c, a, d, m, 1'b0, rd, flt);
        chk($sformatf("rand[%0d] op%0d rdata", i, n), rd, exp_rd);
        chk($sformatf("rand[%0d] op%0d fault", i, n), 32'(flt), 32'(exp_f));
      end
    end

    // Reset one cycle after accept on LATENCY=3: the pending write is dropped.
    do_op(2, 1'b1, 32'h20, 32'h0BAD_F00D, 4'hF, 1'b0, rd, flt);
    @(negedge clk);
    en[2] = 1'b1; cmd = 1'b1; addr = 32'h20; wdata = 32'h1234_5678; mask = 4'hF;
    @(negedge clk);
    en[2] = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("midreset_ready", 32'(ready[2]), 32'd1);
      chk("midreset_valid", 32'(valid[2]), 32'd0);
      @(negedge clk);
    end
    do_op(2, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, rd, flt);
    chk("midreset_old_data", rd, 32'h0BAD_F00D);

    // Reset during the RESPOND cycle on LATENCY=2: the write already committed stays.
    @(negedge clk);
    en[1] = 1'b1; cmd = 1'b1; addr = 32'h24; wdata = 32'hCAFE_F00D; mask = 4'hF;
    @(negedge clk);
    en[1] = 1'b0;
    @(negedge clk);
    chk("respreset_valid_shown", 32'(valid[1]), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("respreset_ready", 32'(ready[1]), 32'd1);
    chk("respreset_valid", 32'(valid[1]), 32'd0);
    chk("respreset_rdata_cleared", rdata[1], 32'd0);
    do_op(1, 1'b0, 32'h24, 32'h0, 4'h0, 1'b0, rd, flt);
    chk("respreset_write_kept", rd, 32'hCAFE_F00D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
